// File: rtl/tick_pwm.sv
// rtl/tick_pwm.sv - tick-driven PWM generator with double-buffered period/duty
`timescale 1ns/1ps

module tick_pwm #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         enable,
  input  logic [W-1:0] period,
  input  logic [W-1:0] duty,
  input  logic         load,
  output logic         load_ack,
  output logic         pwm_out,
  output logic         period_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state, state_next;
  logic [W-1:0] per_s, duty_s;
  logic [W-1:0] per_a, duty_a;
  logic [W-1:0] cnt;
  logic         pend;

  logic [W-1:0] per_next, duty_next, cnt_next;
  logic         wrap, xfer, pend_next, pwm_next, done_next;

  // A wrap only counts while still enabled; a disable wins and suppresses period_done.
  always_comb begin
    wrap      = (state == RUN) && enable && tick && (cnt == per_a - ONE);
    xfer      = pend && ((state == IDLE) || wrap);
    per_next  = xfer ? per_s  : per_a;
    duty_next = xfer ? duty_s : duty_a;
    pend_next = load || (pend && !xfer);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable && (per_next != '0)) state_next = RUN;
      RUN:  if (!enable || (wrap && (per_next == '0))) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output is derived from the post-edge count and duty, so duty=0 is always low
  // and duty>=period is always high without special cases.
  always_comb begin
    cnt_next  = '0;
    pwm_next  = 1'b0;
    done_next = wrap;
    if (state_next == RUN) begin
      if (state == RUN && tick && !wrap) begin
        cnt_next = cnt + ONE;
      end else if (state == RUN && !tick) begin
        cnt_next = cnt;
      end
      pwm_next = (cnt_next < duty_next);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_s       <= '0;
      duty_s      <= '0;
      pend        <= 1'b0;
      per_a       <= '0;
      duty_a      <= '0;
      cnt         <= '0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      if (load) begin
        per_s  <= period;
        duty_s <= duty;
      end
      pend        <= pend_next;
      per_a       <= per_next;
      duty_a      <= duty_next;
      cnt         <= cnt_next;
      pwm_out     <= pwm_next;
      period_done <= done_next;
      load_ack    <= xfer;
    end
  end

endmodule

// File: tb/tb_tick_pwm.sv
// tb/tb_tick_pwm.sv - self-checking bench for tick_pwm
`timescale 1ns/1ps

module tb_tick_pwm;

  typedef struct {
    logic       tick;
    logic       enable;
    logic       load;
    logic [7:0] period;
    logic [7:0] duty;
    logic [2:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] period = '0;
  logic [7:0] duty = '0;
  logic       load = 1'b0;
  logic       load_ack, pwm_out, period_done;

  int checks = 0;
  int errors = 0;

  vec_t       vecs[$];
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  tick_pwm #(.W(8)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .enable(enable),
    .period(period),
    .duty(duty),
    .load(load),
    .load_ack(load_ack),
    .pwm_out(pwm_out),
    .period_done(period_done)
  );

  task automatic check_out(input string name);
    logic [2:0] ex;
    logic [2:0] got;
    checks++;
    got = {pwm_out, period_done, load_ack};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got pwm/done/ack=%b", name, got);
    end else begin
      ex = sb.pop_front();
      if (got !== ex) begin
        errors++;
        $display("FAIL %s: got pwm/done/ack=%b expected %b", name, got, ex);
      end
    end
  endtask

  task automatic step(input logic t, input logic e, input logic l,
                      input logic [7:0] p, input logic [7:0] d,
                      input logic [2:0] ex, input string name);
    tick = t; enable = e; load = l; period = p; duty = d;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic add(input logic t, input logic e, input logic l,
                     input logic [7:0] p, input logic [7:0] d, input logic [2:0] ex);
    vec_t v;
    v.tick = t; v.enable = e; v.load = l; v.period = p; v.duty = d; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].tick, vecs[i].enable, vecs[i].load, vecs[i].period, vecs[i].duty,
           vecs[i].exp, $sformatf("%s[%0d]", name, i));
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int ticks;
    logic t;

    // reset state
    @(posedge clk);
    #1;
    sb.push_back(3'b000);
    check_out("reset");
    reset = 1'b0;

    // expected columns: {pwm_out, period_done, load_ack} after the edge
    add(0,1,1,4,1, 3'b000);
    add(1,1,0,0,0, 3'b101);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b110);
    add(0,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b110);
    run_vecs("basic");

    add(1,1,0,0,0, 3'b000);
    add(1,1,1,8,6, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b111);
    for (int i = 0; i < 5; i++) add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b110);
    add(1,1,0,0,0, 3'b100);
    run_vecs("midrun");

    add(0,0,0,0,0, 3'b000);
    add(0,0,1,3,5, 3'b000);
    add(1,1,0,0,0, 3'b101);
    add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b110);
    add(1,1,0,0,0, 3'b100);
    add(1,1,1,0,0, 3'b100);
    add(1,1,0,0,0, 3'b011);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    run_vecs("p3d5_to_p0");

    add(0,1,1,3,0, 3'b000);
    add(1,1,0,0,0, 3'b001);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b010);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b010);
    run_vecs("p3d0");

    add(0,0,1,0,0, 3'b000);
    add(1,1,0,0,0, 3'b001);
    for (int i = 0; i < 4; i++) add(1,1,0,0,0, 3'b000);
    run_vecs("p0_idle");

    add(0,1,1,4,1, 3'b000);
    add(1,1,0,0,0, 3'b101);
    add(1,1,1,5,2, 3'b000);
    add(1,1,1,6,3, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b111);
    add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b110);
    add(1,1,0,0,0, 3'b100);
    run_vecs("double_load");

    // load on a wrap edge with nothing pending waits a full period
    add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,1,2,2, 3'b110);
    add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b000);
    add(1,1,0,0,0, 3'b111);
    add(1,1,0,0,0, 3'b100);
    add(1,1,0,0,0, 3'b110);
    run_vecs("load_at_wrap");

    // sparse ticks, P=2 D=1
    step(0,0,0,0,0, 3'b000, "sparse_dis");
    step(0,0,1,2,1, 3'b000, "sparse_load");
    step(0,1,0,0,0, 3'b101, "sparse_start");
    ticks = 0;
    for (int k = 1; k <= 4*257; k++) begin
      t = (k % 257 == 0);
      if (t) ticks++;
      step(t,1,0,0,0, {(ticks % 2 == 0), t && (ticks % 2 == 0), 1'b0},
           $sformatf("sparse_clk%0d", k));
    end
    for (int k = 0; k < 100; k++) step(0,1,0,0,0, 3'b100, "sparse_hold");
    step(0,0,0,0,0, 3'b000, "sparse_drop");
    step(1,0,0,0,0, 3'b000, "sparse_idle_tick");
    step(0,0,0,0,0, 3'b000, "sparse_idle");
    step(0,1,0,0,0, 3'b100, "sparse_reenable");
    for (int k = 0; k < 20; k++) step(0,1,0,0,0, 3'b100, "sparse_wait");
    step(1,1,0,0,0, 3'b000, "sparse_tick1");
    step(1,1,0,0,0, 3'b110, "sparse_tick2");

    // asynchronous reset with a load pending
    step(0,1,1,4,4, 3'b100, "rst_pre");
    load = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    sb.push_back(3'b000);
    check_out("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step(1,1,0,0,0, 3'b000, "rst_discard");
    step(0,1,1,2,1, 3'b000, "rst_reload");
    step(1,1,0,0,0, 3'b101, "rst_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
